// File: rtl/cache_l2_pkg.sv
// Shared types and geometry helpers for the N-way L2 cache.
package cache_l2_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } l2_state_t;

  localparam int unsigned DEF_WAYS      = 2;
  localparam int unsigned DEF_SETS      = 32;
  localparam int unsigned DEF_LINE_BITS = 256;
  localparam int unsigned DEF_ADDR_W    = 32;

  function automatic int unsigned off_w(input int unsigned line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                        input int unsigned line_bits);
    return addr_w - idx_w(sets) - off_w(line_bits);
  endfunction

endpackage

// File: rtl/cache_l2_plru.sv
// Per-set tree pseudo-LRU state: WAYS-1 node bits per set, heap-ordered (children 2n+1, 2n+2).
module cache_l2_plru
  import cache_l2_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(SETS)-1:0] index,
  input  logic [$clog2(WAYS)-1:0] access_way,
  input  logic                    update,
  output logic [$clog2(WAYS)-1:0] victim_way
);

  localparam int unsigned LEVELS = $clog2(WAYS);
  localparam int unsigned WAY_W  = $clog2(WAYS);

  logic [WAYS-2:0] tree_q [SETS];
  logic [WAYS-2:0] cur_bits;
  logic [WAYS-2:0] new_bits;
  int              up_node;
  int              vic_node;

  assign cur_bits = tree_q[index];

  // A node bit of 1 steers the victim search to the right child.
  always_comb begin
    new_bits = cur_bits;
    up_node  = int'(access_way) + int'(WAYS) - 1;
    for (int l = 0; l < int'(LEVELS); l++) begin
      new_bits[(up_node - 1) / 2] = up_node[0];
      up_node = (up_node - 1) / 2;
    end
  end

  always_comb begin
    vic_node = 0;
    for (int l = 0; l < int'(LEVELS); l++) begin
      vic_node = 2 * vic_node + 1 + int'(cur_bits[vic_node]);
    end
    victim_way = WAY_W'(vic_node - (int'(WAYS) - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        tree_q[s] <= '0;
      end
    end else if (update) begin
      tree_q[index] <= new_bits;
    end
  end

endmodule

// File: rtl/cache_l2_nway.sv
// N-way set-associative write-back/write-allocate L2 cache with tree PLRU replacement.
// Define CACHE_L2_PERF_EN to add saturating perf_hits/perf_misses counters.
module cache_l2_nway
  import cache_l2_pkg::*;
#(
  parameter int unsigned WAYS      = 2,
  parameter int unsigned SETS      = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 mem_resp,
  output logic [ADDR_W-1:0]    pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
`ifdef CACHE_L2_PERF_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
`endif
);

  localparam int unsigned OFF_W = off_w(LINE_BITS);
  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, SETS, LINE_BITS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  l2_state_t state_q, state_d;

  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] hit_way, free_way, plru_victim;
  logic [TAG_W-1:0] miss_tag_q, req_tag;
  logic [IDX_W-1:0] miss_idx_q, req_idx, cur_idx;
  logic             req, any_hit, any_free, miss, fill_done, plru_update;

  logic [WAYS-1:0]                way_hit, way_valid, way_dirty, data_we, tag_we;
  logic [WAYS-1:0][LINE_BITS-1:0] way_data;
  logic [WAYS-1:0][TAG_W-1:0]     way_tag;
  logic [LINE_BITS-1:0]           data_in;

  assign req       = mem_read | mem_write;
  assign req_tag   = mem_address[ADDR_W-1 -: TAG_W];
  assign req_idx   = mem_address[OFF_W +: IDX_W];
  // Miss handling uses the latched address so a dropped request still fills cleanly.
  assign cur_idx   = (state_q == CHECK) ? req_idx : miss_idx_q;
  assign fill_done = (state_q == FILL) && pmem_resp;
  assign data_in   = (state_q == FILL) ? pmem_rdata : mem_wdata;

  for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
    logic [LINE_BITS-1:0] data_q [SETS];
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;

    always_ff @(posedge clk) begin
      if (data_we[w]) data_q[cur_idx] <= data_in;
      if (tag_we[w])  tag_q[cur_idx]  <= miss_tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        dirty_q <= '0;
      end else if (tag_we[w]) begin
        valid_q[cur_idx] <= 1'b1;
        dirty_q[cur_idx] <= 1'b0;
      end else if (data_we[w]) begin
        dirty_q[cur_idx] <= 1'b1;
      end
    end

    assign way_data[w]  = data_q[cur_idx];
    assign way_tag[w]   = tag_q[cur_idx];
    assign way_valid[w] = valid_q[cur_idx];
    assign way_dirty[w] = dirty_q[cur_idx];
    assign way_hit[w]   = valid_q[cur_idx] && (tag_q[cur_idx] == req_tag);
    assign tag_we[w]    = fill_done && (victim_q == WAY_W'(w));
    assign data_we[w]   = tag_we[w] || ((state_q == CHECK) && mem_write && way_hit[w]);
  end

  // Descending scan so the lowest-index hit/invalid way wins.
  always_comb begin
    any_hit  = |way_hit;
    any_free = 1'b0;
    hit_way  = '0;
    free_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
      if (!way_valid[w]) begin
        any_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  cache_l2_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .index      (cur_idx),
    .access_way (hit_way),
    .update     (plru_update),
    .victim_way (plru_victim)
  );

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    miss         = 1'b0;
    plru_update  = 1'b0;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      CHECK: begin
        if (req && any_hit) begin
          mem_resp    = 1'b1;
          mem_rdata   = way_data[hit_way];
          plru_update = 1'b1;
        end else if (req) begin
          miss     = 1'b1;
          victim_d = any_free ? free_way : plru_victim;
          state_d  = way_dirty[victim_d] ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_q], miss_idx_q, {OFF_W{1'b0}}};
        pmem_wdata   = way_data[victim_q];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        if (pmem_resp) state_d = CHECK;
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CHECK;
      victim_q   <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (miss) begin
        miss_tag_q <= req_tag;
        miss_idx_q <= req_idx;
      end
    end
  end

`ifdef CACHE_L2_PERF_EN
  logic [31:0] hits_q, misses_q;
  logic        retry_q;

  // The hit that completes a miss is not a first-cycle hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      retry_q  <= 1'b0;
    end else begin
      retry_q <= fill_done;
      if (mem_resp && !retry_q && (hits_q != '1)) hits_q <= hits_q + 32'd1;
      if (miss && (misses_q != '1)) misses_q <= misses_q + 32'd1;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_l2_nway.sv
// Directed bench: a 2-way and a 4-way instance share stimulus; sel picks the active one.
module tb_cache_l2_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [255:0] mem_wdata, pmem_rdata;
  logic        pmem_resp;

  logic [1:0]         d_read, d_write, d_presp, d_resp, d_pread, d_pwrite;
  logic [1:0][255:0]  d_rdata, d_pwdata;
  logic [1:0][31:0]   d_paddr;
`ifdef CACHE_L2_PERF_EN
  logic [1:0][31:0]   d_hits, d_misses;
`endif

  logic        mem_resp, pmem_read, pmem_write;
  logic [255:0] mem_rdata, pmem_wdata;
  logic [31:0] pmem_address;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] LINE_5A = {32{8'h5A}};
  localparam logic [255:0] LINE_C3 = {32{8'hC3}};

  always #5 clk = ~clk;

  assign d_read  = {mem_read & sel, mem_read & ~sel};
  assign d_write = {mem_write & sel, mem_write & ~sel};
  assign d_presp = {pmem_resp & sel, pmem_resp & ~sel};

  assign mem_resp     = d_resp[sel];
  assign mem_rdata    = d_rdata[sel];
  assign pmem_read    = d_pread[sel];
  assign pmem_write   = d_pwrite[sel];
  assign pmem_wdata   = d_pwdata[sel];
  assign pmem_address = d_paddr[sel];

  cache_l2_nway #(.WAYS(2), .SETS(32), .LINE_BITS(256), .ADDR_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(d_read[0]),
    .mem_write(d_write[0]), .mem_wdata(mem_wdata), .mem_rdata(d_rdata[0]),
    .mem_resp(d_resp[0]), .pmem_address(d_paddr[0]), .pmem_read(d_pread[0]),
    .pmem_write(d_pwrite[0]), .pmem_wdata(d_pwdata[0]), .pmem_rdata(pmem_rdata),
    .pmem_resp(d_presp[0])
`ifdef CACHE_L2_PERF_EN
    , .perf_hits(d_hits[0]), .perf_misses(d_misses[0])
`endif
  );

  cache_l2_nway #(.WAYS(4), .SETS(32), .LINE_BITS(256), .ADDR_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(d_read[1]),
    .mem_write(d_write[1]), .mem_wdata(mem_wdata), .mem_rdata(d_rdata[1]),
    .mem_resp(d_resp[1]), .pmem_address(d_paddr[1]), .pmem_read(d_pread[1]),
    .pmem_write(d_pwrite[1]), .pmem_wdata(d_pwdata[1]), .pmem_rdata(pmem_rdata),
    .pmem_resp(d_presp[1])
`ifdef CACHE_L2_PERF_EN
    , .perf_hits(d_hits[1]), .perf_misses(d_misses[1])
`endif
  );

  function automatic logic [255:0] fill_line(input logic [31:0] addr);
    return {8{addr}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_access(input logic [31:0] addr, input bit wr, input logic [255:0] wdata,
                            input logic [255:0] exp_rdata, input string tag);
    mem_address = addr;
    mem_read    = !wr;
    mem_write   = wr;
    mem_wdata   = wdata;
    #1;
    check({tag, ":resp"}, mem_resp, 1'b1);
    if (!wr) check({tag, ":rdata"}, mem_rdata, exp_rdata);
    check({tag, ":pmem_idle"}, {pmem_read, pmem_write}, 2'b00);
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check({tag, ":resp_pulse"}, mem_resp, 1'b0);
    tick();
  endtask

  // Miss path: optional writeback, then fill answered immediately, then the retried hit.
  task automatic miss_access(input logic [31:0] addr, input bit wr, input logic [255:0] wdata,
                             input bit exp_wb, input logic [31:0] wb_addr,
                             input logic [255:0] wb_data, input string tag);
    mem_address = addr;
    mem_read    = !wr;
    mem_write   = wr;
    mem_wdata   = wdata;
    #1;
    check({tag, ":miss_noresp"}, mem_resp, 1'b0);
    tick();
    if (exp_wb) begin
      check({tag, ":wb_write"}, {pmem_write, pmem_read}, 2'b10);
      check({tag, ":wb_addr"}, pmem_address, wb_addr);
      check({tag, ":wb_data"}, pmem_wdata, wb_data);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
    end else begin
      check({tag, ":no_wb"}, pmem_write, 1'b0);
    end
    check({tag, ":fill_read"}, {pmem_read, pmem_write}, 2'b10);
    check({tag, ":fill_addr"}, pmem_address, addr & ~32'h1f);
    pmem_rdata = fill_line(addr);
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    check({tag, ":resp"}, mem_resp, 1'b1);
    if (!wr) check({tag, ":rdata"}, mem_rdata, fill_line(addr));
    check({tag, ":pmem_done"}, {pmem_read, pmem_write}, 2'b00);
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:mem_resp", mem_resp, 1'b0);
    check("rst:pmem_rw", {pmem_read, pmem_write}, 2'b00);
    check("rst:mem_rdata", mem_rdata, '0);
    check("rst:pmem_wdata", pmem_wdata, '0);
    rst = 1'b0;
    tick();

    // 2-way: cold miss, repeat hit, then dirty eviction of 0x1000 by 0x3000.
    miss_access(32'h0000_1000, 1'b0, '0, 1'b0, '0, '0, "t1_cold");
    hit_access(32'h0000_1000, 1'b0, '0, fill_line(32'h0000_1000), "t2_hit");
    hit_access(32'h0000_1000, 1'b1, LINE_A5, '0, "t3_wr");
    miss_access(32'h0000_2000, 1'b0, '0, 1'b0, '0, '0, "t3_2000");
    miss_access(32'h0000_3000, 1'b0, '0, 1'b1, 32'h0000_1000, LINE_A5, "t3_evict");
    hit_access(32'h0000_2000, 1'b0, '0, fill_line(32'h0000_2000), "t3_keep");

    // 4-way: after A,B,C,D,A the tree points at way 2, so E replaces C.
    sel = 1'b1;
    miss_access(32'h0000_1000, 1'b0, '0, 1'b0, '0, '0, "t4_A");
    miss_access(32'h0000_2000, 1'b0, '0, 1'b0, '0, '0, "t4_B");
    miss_access(32'h0000_3000, 1'b0, '0, 1'b0, '0, '0, "t4_C");
    miss_access(32'h0000_4000, 1'b0, '0, 1'b0, '0, '0, "t4_D");
    hit_access(32'h0000_1000, 1'b0, '0, fill_line(32'h0000_1000), "t4_A2");
    miss_access(32'h0000_5000, 1'b0, '0, 1'b0, '0, '0, "t4_E");
    hit_access(32'h0000_2000, 1'b0, '0, fill_line(32'h0000_2000), "t4_Bkept");
    hit_access(32'h0000_4000, 1'b0, '0, fill_line(32'h0000_4000), "t4_Dkept");
    hit_access(32'h0000_1000, 1'b0, '0, fill_line(32'h0000_1000), "t4_Akept");
    hit_access(32'h0000_5000, 1'b0, '0, fill_line(32'h0000_5000), "t4_Ehit");
    miss_access(32'h0000_3000, 1'b0, '0, 1'b0, '0, '0, "t4_Cgone");

    // 2-way: reset during writeback of dirty 0x2000, then everything misses clean.
    sel = 1'b0;
    hit_access(32'h0000_2000, 1'b1, LINE_5A, '0, "t5_wr2000");
    hit_access(32'h0000_3000, 1'b1, LINE_C3, '0, "t5_wr3000");
    mem_address = 32'h0000_4000;
    mem_read    = 1'b1;
    #1;
    check("t5:miss_noresp", mem_resp, 1'b0);
    tick();
    check("t5:wb_write", pmem_write, 1'b1);
    check("t5:wb_addr", pmem_address, 32'h0000_2000);
    check("t5:wb_data", pmem_wdata, LINE_5A);
    #2;
    rst = 1'b1;
    #1;
    check("t5:rst_pmem", {pmem_read, pmem_write}, 2'b00);
    check("t5:rst_resp", mem_resp, 1'b0);
    mem_read = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    miss_access(32'h0000_3000, 1'b0, '0, 1'b0, '0, '0, "t5_after_rst");

`ifdef CACHE_L2_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t6:hits0", d_hits[0], 32'd0);
    check("t6:misses0", d_misses[0], 32'd0);
    miss_access(32'h0000_1000, 1'b0, '0, 1'b0, '0, '0, "t6_mA");
    hit_access(32'h0000_1000, 1'b0, '0, fill_line(32'h0000_1000), "t6_h1");
    hit_access(32'h0000_1000, 1'b0, '0, fill_line(32'h0000_1000), "t6_h2");
    miss_access(32'h0000_2000, 1'b0, '0, 1'b0, '0, '0, "t6_mB");
    hit_access(32'h0000_2000, 1'b0, '0, fill_line(32'h0000_2000), "t6_h3");
    hit_access(32'h0000_1000, 1'b1, LINE_A5, '0, "t6_h4");
    hit_access(32'h0000_1000, 1'b0, '0, LINE_A5, "t6_h5");
    miss_access(32'h0000_5000, 1'b0, '0, 1'b0, '0, '0, "t6_m3");
    check("t6:hits", d_hits[0], 32'd5);
    check("t6:misses", d_misses[0], 32'd3);
    rst = 1'b1;
    #1;
    check("t6:rst_hits", d_hits[0], 32'd0);
    check("t6:rst_misses", d_misses[0], 32'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
